// File: rtl/multicycle_control.sv
// Multicycle datapath control: Moore FSM plus ALU decoder driving the ALU operation select.
// Optional macro BNE_EN adds bne (op 000101) as a branch-on-not-equal through the BRANCH state.
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_BAD = 3'b111;

  state_t state_q, state_d;
  logic   pc_write, branch, branch_ne;
  logic   ir_w, mem_w, reg_w, illegal;
  logic   branch_taken;

  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      6'b100000: alu_decode = ALU_ADD;
      6'b100010: alu_decode = ALU_SUB;
      6'b100100: alu_decode = ALU_AND;
      6'b100101: alu_decode = ALU_OR;
      6'b101010: alu_decode = ALU_SLT;
      default:   alu_decode = ALU_BAD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    ir_w        = 1'b0;
    mem_w       = 1'b0;
    reg_w       = 1'b0;
    illegal     = 1'b0;
    i_or_d      = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        ir_w      = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        // ALU speculatively forms PC + (imm<<2) so BRANCH can use ALUOut
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        i_or_d = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        state_d     = S_ALUWB;
        alu_src_a   = 1'b1;
        alu_control = alu_decode(funct);
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
`ifdef BNE_EN
        branch_ne   = (op == OP_BNE);
        branch      = ~branch_ne;
`else
        branch      = 1'b1;
`endif
      end
      S_ADDIEX: begin
        state_d   = S_ADDIWB;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_w = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked by reset so nothing writes while the async reset is held
  assign branch_taken = (branch & zero) | (branch_ne & ~zero);
  assign pc_en        = ~reset & (pc_write | branch_taken);
  assign ir_write     = ~reset & ir_w;
  assign mem_write    = ~reset & mem_w;
  assign reg_write    = ~reset & reg_w;
  assign illegal_op   = ~reset & illegal;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two DUTs (ILLEGAL_TRAP 0 and 1) on shared inputs, checked every
// cycle against a queue-of-planned-states model, plus directed literal checks.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       pc_en0, ir_write0, mem_write0, reg_write0, i_or_d0, mem_to_reg0, reg_dst0, alu_src_a0;
  logic [1:0] alu_src_b0, pc_src0;
  logic [2:0] alu_control0;
  logic       illegal_op0;
  logic [3:0] state0;
  logic       pc_en1, ir_write1, mem_write1, reg_write1, i_or_d1, mem_to_reg1, reg_dst1, alu_src_a1;
  logic [1:0] alu_src_b1, pc_src1;
  logic [2:0] alu_control1;
  logic       illegal_op1;
  logic [3:0] state1;

  multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en0), .ir_write(ir_write0), .mem_write(mem_write0), .reg_write(reg_write0),
    .i_or_d(i_or_d0), .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .alu_src_a(alu_src_a0),
    .alu_src_b(alu_src_b0), .pc_src(pc_src0), .alu_control(alu_control0),
    .illegal_op(illegal_op0), .state(state0)
  );

  multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en1), .ir_write(ir_write1), .mem_write(mem_write1), .reg_write(reg_write1),
    .i_or_d(i_or_d1), .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .alu_src_a(alu_src_a1),
    .alu_src_b(alu_src_b1), .pc_src(pc_src1), .alu_control(alu_control1),
    .illegal_op(illegal_op1), .state(state1)
  );

  logic [19:0] act0, act1;
  assign act0 = {pc_en0, ir_write0, mem_write0, reg_write0, i_or_d0, mem_to_reg0, reg_dst0,
                 alu_src_a0, alu_src_b0, pc_src0, alu_control0, illegal_op0, state0};
  assign act1 = {pc_en1, ir_write1, mem_write1, reg_write1, i_or_d1, mem_to_reg1, reg_dst1,
                 alu_src_a1, alu_src_b1, pc_src1, alu_control1, illegal_op1, state1};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each DUT k holds a current state and a plan of upcoming states chosen at DECODE.
  int mcur[2] = '{0, 0};
  int plan[2][4];
  int plen[2] = '{0, 0};
  int pidx[2] = '{0, 0};

  function automatic bit is_bne(input logic [5:0] o);
`ifdef BNE_EN
    return o == 6'b000101;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mcur[k] = 0;
        plen[k] = 0;
        pidx[k] = 0;
      end else if (mcur[k] == 12) begin
        mcur[k] = 12;
      end else if (mcur[k] == 1) begin
        plen[k] = 0;
        pidx[k] = 0;
        if (op == 6'b100011) begin plan[k][0] = 2; plan[k][1] = 3; plan[k][2] = 4; plen[k] = 3; end
        else if (op == 6'b101011) begin plan[k][0] = 2; plan[k][1] = 5; plen[k] = 2; end
        else if (op == 6'b000000) begin plan[k][0] = 6; plan[k][1] = 7; plen[k] = 2; end
        else if (op == 6'b000100 || is_bne(op)) begin plan[k][0] = 8; plen[k] = 1; end
        else if (op == 6'b001000) begin plan[k][0] = 9; plan[k][1] = 10; plen[k] = 2; end
        else if (op == 6'b000010) begin plan[k][0] = 11; plen[k] = 1; end
        else if (k == 1) begin plan[k][0] = 12; plen[k] = 1; end
        if (plen[k] > 0) begin mcur[k] = plan[k][0]; pidx[k] = 1; end
        else mcur[k] = 0;
      end else if (pidx[k] < plen[k]) begin
        mcur[k] = plan[k][pidx[k]];
        pidx[k]++;
      end else if (mcur[k] == 0) begin
        mcur[k] = 1;
      end else begin
        mcur[k] = 0;
        plen[k] = 0;
        pidx[k] = 0;
      end
    end
  end

  function automatic logic [2:0] funct_op(input logic [5:0] f);
    logic [5:0] keys [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] vals [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    for (int i = 0; i < 5; i++) if (keys[i] == f) return vals[i];
    return 3'b111;
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
           o == 6'b001000 || o == 6'b000010 || is_bne(o);
  endfunction

  function automatic logic [19:0] exp_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic rst);
    logic pcw, br, ir, mw, rw, iord, m2r, rdst, sa, ill, pe;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {pcw, br, ir, mw, rw, iord, m2r, rdst, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    if (st == 0) begin ir = 1; pcw = 1; sb = 2'b01; end
    if (st == 1) begin sb = 2'b11; ill = !legal(o); end
    if (st == 2 || st == 9) begin sa = 1; sb = 2'b10; end
    if (st == 3) iord = 1;
    if (st == 4) begin rw = 1; m2r = 1; end
    if (st == 5) begin iord = 1; mw = 1; end
    if (st == 6) begin sa = 1; alu = funct_op(f); end
    if (st == 7) begin rw = 1; rdst = 1; end
    if (st == 8) begin sa = 1; alu = 3'b001; ps = 2'b01; br = 1; end
    if (st == 10) rw = 1;
    if (st == 11) begin ps = 2'b10; pcw = 1; end
    pe = pcw | (br & (is_bne(o) ? ~z : z));
    if (rst) begin pe = 0; ir = 0; mw = 0; rw = 0; ill = 0; end
    return {pe, ir, mw, rw, iord, m2r, rdst, sa, sb, ps, alu, ill, 4'(st)};
  endfunction

  always @(negedge clk) begin
    chk("cycle_dut0", 32'(act0), 32'(exp_out(mcur[0], op, funct, zero, reset)));
    chk("cycle_dut1", 32'(act1), 32'(exp_out(mcur[1], op, funct, zero, reset)));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  logic [5:0] fl [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [2:0] al [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b111};
  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (3) step();
    chk("reset_enables", 32'({pc_en0, ir_write0, mem_write0, reg_write0, illegal_op0}), 32'd0);
    chk("reset_state", 32'(state0), 32'd0);
    reset = 1'b0;
    op = 6'b100011;
    #1;
    chk("post_reset_state", 32'(state0), 32'd0);
    chk("post_reset_ir_pc", 32'({ir_write0, pc_en0}), 32'b11);
    // lw: 0,1,2,3,4,0
    step(); chk("lw_s1", 32'(state0), 32'd1);
    step(); chk("lw_s2", 32'(state0), 32'd2);
    step(); chk("lw_s3", 32'({state0, i_or_d0, reg_write0}), {26'd0, 4'd3, 2'b10});
    step(); chk("lw_s4", 32'({state0, reg_write0, mem_to_reg0}), {26'd0, 4'd4, 2'b11});
    step(); chk("lw_s0", 32'(state0), 32'd0);
    // R-type with each funct
    for (int i = 0; i < 6; i++) begin
      op = 6'b000000;
      step(); step();
      funct = fl[i];
      #1;
      chk($sformatf("rtype_alu_%0d", i), 32'({state0, alu_control0}), {25'd0, 4'd6, al[i]});
      step();
      chk($sformatf("rtype_wb_%0d", i), 32'({state0, reg_write0, reg_dst0}), {26'd0, 4'd7, 2'b11});
      step();
    end
    // beq
    op = 6'b000100;
    step(); step();
    zero = 1'b1; #1;
    chk("beq_taken", 32'({state0, pc_en0, pc_src0}), {25'd0, 4'd8, 1'b1, 2'b01});
    zero = 1'b0; #1;
    chk("beq_not_taken", 32'(pc_en0), 32'd0);
    step(); chk("beq_back", 32'(state0), 32'd0);
    // illegal opcode
    op = 6'b111111;
    step(); #1;
    chk("illegal_pulse", 32'({illegal_op0, illegal_op1}), 32'b11);
    step();
    chk("illegal_fetch", 32'({state0, illegal_op0}), {27'd0, 4'd0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold", 32'({state1, pc_en1, ir_write1, mem_write1, reg_write1}), {24'd0, 4'd12, 4'd0});
      step();
    end
    reset = 1'b1; #1;
    chk("halt_exit_reset", 32'(state1), 32'd0);
    step(); reset = 1'b0;
    // sw interrupted by reset in MEMWRITE
    op = 6'b101011;
    step(); step(); step();
    chk("sw_memwrite", 32'({state0, mem_write0}), {27'd0, 4'd5, 1'b1});
    #1 reset = 1'b1;
    #1 chk("sw_async_reset", 32'({state0, mem_write0}), 32'd0);
    step(); reset = 1'b0;
    // bne
    op = 6'b000101;
    step();
`ifdef BNE_EN
    step(); zero = 1'b0; #1;
    chk("bne_taken", 32'({state0, pc_en0}), {27'd0, 4'd8, 1'b1});
    zero = 1'b1; #1;
    chk("bne_not_taken", 32'(pc_en0), 32'd0);
    step();
`else
    #1;
    chk("bne_illegal", 32'({state0, illegal_op0}), {27'd0, 4'd1, 1'b1});
    step();
`endif
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      zero  = 1'($urandom_range(0, 1));
      funct = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 4)] : 6'($urandom);
      if (mcur[0] == 0)
        op = ($urandom_range(0, 7) != 0) ? ops[$urandom_range(0, 5)] : 6'($urandom);
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
